// File: rtl/smoldvi_tmds_encoder.sv
// Per-lane DVI TMDS encoder: 8b pixel / 2b control code to DC-balanced 10b symbol.
// Define SMOLDVI_TMDS_PIPE_EN to register the transition-minimised word (2-clk latency).
module smoldvi_tmds_encoder #(
    parameter int unsigned CNT_W = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       de,
    input  logic [7:0] d,
    input  logic [1:0] c,
    output logic [9:0] q
);

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;
    localparam logic signed [CNT_W-1:0] TWO = CNT_W'(2);

    logic [7:0] d_g;
    logic [3:0] n1d;
    logic       use_xnor;
    logic [8:0] qm_a;

    // Stage A: transition minimisation; d is masked in blanking so X on d cannot leak.
    always_comb begin
        d_g      = de ? d : 8'h00;
        n1d      = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n1d = n1d + 4'(d_g[i]);
        end
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d_g[0]);
        qm_a     = 9'h000;
        qm_a[0]  = d_g[0];
        for (int i = 1; i < 8; i++) begin
            qm_a[i] = use_xnor ? ~(qm_a[i-1] ^ d_g[i]) : (qm_a[i-1] ^ d_g[i]);
        end
        qm_a[8]  = !use_xnor;
    end

    logic [8:0] qm_b;
    logic       de_b;
    logic [1:0] c_b;

`ifdef SMOLDVI_TMDS_PIPE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qm_b <= 9'h000;
            de_b <= 1'b0;
            c_b  <= 2'b00;
        end else begin
            qm_b <= qm_a;
            de_b <= de;
            c_b  <= c;
        end
    end
`else
    assign qm_b = qm_a;
    assign de_b = de;
    assign c_b  = c;
`endif

    logic signed [CNT_W-1:0] cnt;
    logic signed [CNT_W-1:0] cnt_nxt;
    logic signed [CNT_W-1:0] bal;
    logic [3:0]              n1;
    logic [3:0]              n0;
    logic                    cnt_pos;
    logic                    cnt_neg;
    logic [9:0]              q_nxt;

    // Stage B: DC balance against the running disparity, or control symbol in blanking.
    always_comb begin
        n1 = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n1 = n1 + 4'(qm_b[i]);
        end
        n0      = 4'd8 - n1;
        bal     = $signed(CNT_W'(n1)) - $signed(CNT_W'(n0));
        cnt_neg = cnt[CNT_W-1];
        cnt_pos = !cnt[CNT_W-1] && (cnt != '0);
        q_nxt   = CTRL_00;
        cnt_nxt = '0;
        if (de_b) begin
            if ((cnt == '0) || (n1 == n0)) begin
                q_nxt   = {~qm_b[8], qm_b[8], qm_b[8] ? qm_b[7:0] : ~qm_b[7:0]};
                cnt_nxt = qm_b[8] ? (cnt + bal) : (cnt - bal);
            end else if ((cnt_pos && (n1 > n0)) || (cnt_neg && (n0 > n1))) begin
                q_nxt   = {1'b1, qm_b[8], ~qm_b[7:0]};
                cnt_nxt = cnt + (qm_b[8] ? TWO : '0) - bal;
            end else begin
                q_nxt   = {1'b0, qm_b[8], qm_b[7:0]};
                cnt_nxt = cnt - (qm_b[8] ? '0 : TWO) + bal;
            end
        end else begin
            unique case (c_b)
                2'b00:   q_nxt = CTRL_00;
                2'b01:   q_nxt = CTRL_01;
                2'b10:   q_nxt = CTRL_10;
                default: q_nxt = CTRL_11;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= CTRL_00;
            cnt <= '0;
        end else begin
            q   <= q_nxt;
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_smoldvi_tmds_encoder.sv
// Directed vector bench for smoldvi_tmds_encoder; follows the pipelined build when
// SMOLDVI_TMDS_PIPE_EN is defined.
module tb_smoldvi_tmds_encoder;

`ifdef SMOLDVI_TMDS_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int NV = 20;

    typedef struct packed {
        logic       de;
        logic [7:0] d;
        logic [1:0] c;
        logic [9:0] exp;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       de;
    logic [7:0] d;
    logic [1:0] c;
    logic [9:0] q;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[NV];

    smoldvi_tmds_encoder #(.CNT_W(6)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .de   (de),
        .d    (d),
        .c    (c),
        .q    (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic v_de, input logic [7:0] v_d,
                                input logic [1:0] v_c, input logic [9:0] v_exp);
        vec_t v;
        v.de = v_de; v.d = v_d; v.c = v_c; v.exp = v_exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [9:0] exp);
        n_checks++;
        if (q !== exp) begin
            n_fail++;
            $display("FAIL %s: q=0x%03h expected 0x%03h", name, q, exp);
        end
    endtask

    initial begin
        // One continuous stream; disparity comments give cnt after each symbol.
        vecs[0]  = mk(1'b0, 8'hA5, 2'b00, 10'h354);
        vecs[1]  = mk(1'b0, 8'h3C, 2'b01, 10'h0AB);
        vecs[2]  = mk(1'b0, 8'hFF, 2'b10, 10'h154);
        vecs[3]  = mk(1'b0, 8'h00, 2'b11, 10'h2AB);
        vecs[4]  = mk(1'b1, 8'h00, 2'b01, 10'h100); // -8
        vecs[5]  = mk(1'b1, 8'h00, 2'b00, 10'h3FF); // +2
        vecs[6]  = mk(1'b1, 8'h00, 2'b00, 10'h100); // -6
        vecs[7]  = mk(1'b0, 8'hFF, 2'b00, 10'h354); // 0
        vecs[8]  = mk(1'b1, 8'hFF, 2'b00, 10'h200); // -8, XNOR path
        vecs[9]  = mk(1'b0, 8'h00, 2'b00, 10'h354);
        vecs[10] = mk(1'b1, 8'h00, 2'b00, 10'h100); // -8
        vecs[11] = mk(1'b1, 8'h00, 2'b00, 10'h3FF); // +2
        vecs[12] = mk(1'b0, 8'h00, 2'b00, 10'h354); // blanking clears cnt
        vecs[13] = mk(1'b1, 8'h00, 2'b00, 10'h100); // -8 from zero
        vecs[14] = mk(1'b0, 8'h5A, 2'b00, 10'h354);
        vecs[15] = mk(1'b1, 8'h0F, 2'b00, 10'h105); // n1d==4, d0=1: XOR, -4
        vecs[16] = mk(1'b1, 8'h10, 2'b00, 10'h1F0); // balanced qm, -4
        vecs[17] = mk(1'b1, 8'h1E, 2'b00, 10'h25F); // n1d==4, d0=0: XNOR, 0
        vecs[18] = mk(1'b1, 8'h00, 2'b11, 10'h100); // c ignored, -8
        vecs[19] = mk(1'b0, 8'hAA, 2'b10, 10'h154); // d ignored

        // Reset held with random inputs
        rst_n = 1'b0;
        de = 1'b0; d = 8'h00; c = 2'b00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("reset_hold%0d", i), 10'h354);
            de = 1'($urandom); d = 8'($urandom); c = 2'($urandom);
        end
        @(negedge clk);
        rst_n = 1'b1;
        de = 1'b0; d = 8'h00; c = 2'b00;
        for (int i = 0; i <= LAT; i++) begin
            @(negedge clk);
            check($sformatf("post_release%0d", i), 10'h354);
        end

        // Table stream, compared LAT clocks after each vector is applied
        for (int s = 0; s < NV + LAT; s++) begin
            @(negedge clk);
            if (s >= LAT) check($sformatf("vec%0d", s - LAT), vecs[s - LAT].exp);
            if (s < NV) begin
                de = vecs[s].de; d = vecs[s].d; c = vecs[s].c;
            end else begin
                de = 1'b0; d = 8'h00; c = 2'b00;
            end
        end

        // Mid-line reset with non-zero disparity
        de = 1'b1; d = 8'h00; c = 2'b00;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_async", 10'h354);
        @(negedge clk);
        check("rst_during", 10'h354);
        rst_n = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            check($sformatf("rst_resume%0d", k), (k == LAT) ? 10'h100 : 10'h354);
        end
        @(negedge clk);
        check("rst_resume_next", 10'h3FF);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
